// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential execute-stage ALU.
package seq_alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLT  = 4'd5,
      OP_SLTU = 4'd6,
      OP_MUL  = 4'd7
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int FLAG_V = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, BITS cycles
// after start. done_o marks the final iteration; product_o is valid with it.
module seq_alu_mul #(
   parameter int BITS  = 64,
   parameter int CNT_W = $clog2(BITS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [BITS-1:0] a_i,
   input  logic [BITS-1:0] b_i,
   output logic            done_o,
   output logic [BITS-1:0] product_o
);

   logic [BITS-1:0]  mcand_q, mplier_q, acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;

   assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign done_o    = busy_q && (cnt_q == '0);
   assign product_o = acc_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start_i) begin
         mcand_q  <= a_i;
         mplier_q <= b_i;
         acc_q    <= '0;
         cnt_q    <= CNT_W'(BITS - 1);
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         if (cnt_q == '0) busy_q <= 1'b0;
         else             cnt_q  <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU with valid/ready on both sides.
// Define SEQ_ALU_MUL_EN to include the multi-cycle MUL path (BUSY state).
//
// state | meaning
// IDLE  | no result held, ready for an op
// BUSY  | multiply iterating, not ready
// DONE  | result/flags held until out_ready
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int BITS  = 64,
   parameter int CNT_W = $clog2(BITS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [BITS-1:0] src_a,
   input  logic [BITS-1:0] src_b,
   input  logic [3:0]      alu_op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BITS-1:0] alu_result,
   output logic [3:0]      alu_flags
);

   state_t          state_q, state_d;
   logic [BITS-1:0] result_q, result_d;
   logic [3:0]      flags_q, flags_d;

   logic            accept, is_sub, is_arith, ovf;
   logic [BITS-1:0] b_eff, simple_res;
   logic [BITS:0]   sum;
   logic [3:0]      simple_flags;

   // SUB reuses the adder as A + ~B + 1 so carry-out doubles as "no borrow"
   assign is_sub   = (alu_op == OP_SUB);
   assign is_arith = (alu_op == OP_ADD) || is_sub;
   assign b_eff    = is_sub ? ~src_b : src_b;
   assign sum      = {1'b0, src_a} + {1'b0, b_eff} + {{BITS{1'b0}}, is_sub};
   assign ovf      = (src_a[BITS-1] == b_eff[BITS-1]) && (sum[BITS-1] != src_a[BITS-1]);

   always_comb begin
      simple_res = '0;
      case (alu_op)
         OP_ADD, OP_SUB: simple_res = sum[BITS-1:0];
         OP_AND:         simple_res = src_a & src_b;
         OP_OR:          simple_res = src_a | src_b;
         OP_XOR:         simple_res = src_a ^ src_b;
         OP_SLT:         simple_res = {{(BITS-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         OP_SLTU:        simple_res = {{(BITS-1){1'b0}}, src_a < src_b};
         default:        simple_res = '0;
      endcase
   end

   always_comb begin
      simple_flags         = 4'b0000;
      simple_flags[FLAG_V] = is_arith & ovf;
      simple_flags[FLAG_C] = is_arith & sum[BITS];
      simple_flags[FLAG_N] = simple_res[BITS-1];
      simple_flags[FLAG_Z] = (simple_res == '0);
   end

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);

`ifdef SEQ_ALU_MUL_EN
   logic            mul_start, mul_done;
   logic [BITS-1:0] mul_prod;

   seq_alu_mul #(.BITS(BITS), .CNT_W(CNT_W)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start_i   (mul_start),
      .a_i       (src_a),
      .b_i       (src_b),
      .done_o    (mul_done),
      .product_o (mul_prod)
   );
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
`ifdef SEQ_ALU_MUL_EN
      mul_start = 1'b0;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (state_q == DONE && out_ready) state_d = IDLE;
            if (accept) begin
`ifdef SEQ_ALU_MUL_EN
               if (alu_op == OP_MUL) begin
                  mul_start = 1'b1;
                  state_d   = BUSY;
               end else
`endif
               begin
                  result_d = simple_res;
                  flags_d  = simple_flags;
                  state_d  = DONE;
               end
            end
         end
`ifdef SEQ_ALU_MUL_EN
         BUSY: begin
            if (mul_done) begin
               result_d = mul_prod;
               flags_d  = {2'b00, mul_prod[BITS-1], mul_prod == '0};
               state_d  = DONE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         flags_q  <= 4'b0000;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign alu_result = result_q;
   assign alu_flags  = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (BITS=64); MUL checks follow SEQ_ALU_MUL_EN.
module tb_seq_alu;

   localparam int BITS = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [BITS-1:0] src_a, src_b;
   logic [3:0]      alu_op;
   logic            out_valid;
   logic            out_ready;
   logic [BITS-1:0] alu_result;
   logic [3:0]      alu_flags;

   int n_assert = 0;
   int n_fail   = 0;

   seq_alu #(.BITS(BITS)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .src_a      (src_a),
      .src_b      (src_b),
      .alu_op     (alu_op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_result (alu_result),
      .alu_flags  (alu_flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      in_valid = 1'b1;
      alu_op   = op;
      src_a    = a;
      src_b    = b;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int  n;
      logic bad_ready;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      src_a = '0; src_b = '0; alu_op = 4'd0;
      step(); step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result",    alu_result,     64'd0);
      chk("rst_flags",     64'(alu_flags), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      rst = 1'b0;

      // ADD overflow into sign bit
      drive(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      step();
      in_valid = 1'b0;
      chk("add_valid",  64'(out_valid), 64'd1);
      chk("add_result", alu_result,     64'h8000_0000_0000_0000);
      chk("add_flags",  64'(alu_flags), 64'b1010);
      step();
      chk("drain_valid", 64'(out_valid), 64'd0);

      // back-to-back: SUB, SLT, SLTU, SUB borrow, AND, OR, undefined
      drive(4'd1, 64'd5, 64'd5);
      step();
      chk("sub_eq_result", alu_result,     64'd0);
      chk("sub_eq_flags",  64'(alu_flags), 64'b0101);
      drive(4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      step();
      chk("slt_valid",  64'(out_valid), 64'd1);
      chk("slt_result", alu_result,     64'd1);
      chk("slt_flags",  64'(alu_flags), 64'b0000);
      drive(4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      step();
      chk("sltu_result", alu_result,     64'd0);
      chk("sltu_flags",  64'(alu_flags), 64'b0001);
      drive(4'd1, 64'd0, 64'd1);
      step();
      chk("sub_borrow_result", alu_result,     64'hFFFF_FFFF_FFFF_FFFF);
      chk("sub_borrow_flags",  64'(alu_flags), 64'b0010);
      drive(4'd2, 64'hF0, 64'h3C);
      step();
      chk("and_result", alu_result, 64'h30);
      drive(4'd3, 64'hF0, 64'h3C);
      step();
      chk("or_result", alu_result, 64'hFC);
      drive(4'd15, 64'h1234, 64'h5678);
      step();
      chk("undef_result", alu_result,     64'd0);
      chk("undef_flags",  64'(alu_flags), 64'b0001);
      in_valid = 1'b0;
      step();

      // backpressure: XOR held for 5 cycles while inputs wander
      out_ready = 1'b0;
      drive(4'd4, 64'hF0, 64'hFF);
      step();
      in_valid = 1'b0; src_a = 64'hDEAD; src_b = 64'hBEEF; alu_op = 4'd0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid",    64'(out_valid), 64'd1);
         chk("bp_result",   alu_result,     64'h0F);
         chk("bp_in_ready", 64'(in_ready),  64'd0);
         step();
      end
      out_ready = 1'b1;
      drive(4'd0, 64'd2, 64'd3);
      #1;
      chk("bp_release_ready", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      chk("bp_next_valid",  64'(out_valid), 64'd1);
      chk("bp_next_result", alu_result,     64'd5);
      step();

`ifdef SEQ_ALU_MUL_EN
      // MUL 12*13, latency 64
      drive(4'd7, 64'd12, 64'd13);
      step();
      in_valid = 1'b0;
      n = 0; bad_ready = 1'b0;
      while (!out_valid && n < 200) begin
         if (in_ready) bad_ready = 1'b1;
         step();
         n++;
      end
      chk("mul_ready_low", 64'(bad_ready), 64'd0);
      chk("mul_latency",   64'(n),         64'd64);
      chk("mul_result",    alu_result,     64'd156);
      chk("mul_flags",     64'(alu_flags), 64'b0000);
      // wraparound product: -1 * 3 = -3
      drive(4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin
         step();
         n++;
      end
      chk("mul_wrap_latency", 64'(n),         64'd64);
      chk("mul_wrap_result",  alu_result,     64'hFFFF_FFFF_FFFF_FFFD);
      chk("mul_wrap_flags",   64'(alu_flags), 64'b0010);
      step();
      // reset mid-multiply
      drive(4'd7, 64'd7, 64'd9);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 19; i++) step();
      chk("mul_mid_valid", 64'(out_valid), 64'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mulrst_valid",    64'(out_valid), 64'd0);
      chk("mulrst_result",   alu_result,     64'd0);
      chk("mulrst_flags",    64'(alu_flags), 64'd0);
      chk("mulrst_in_ready", 64'(in_ready),  64'd1);
      for (int i = 0; i < 70; i++) begin
         if (out_valid) bad_ready = 1'b1;
         step();
      end
      chk("mulrst_no_emit", 64'(bad_ready), 64'd0);
`else
      drive(4'd7, 64'd3, 64'd4);
      step();
      in_valid = 1'b0;
      chk("mul_off_valid",  64'(out_valid), 64'd1);
      chk("mul_off_result", alu_result,     64'd0);
      chk("mul_off_flags",  64'(alu_flags), 64'b0001);
      step();
      // reset while a result is held
      out_ready = 1'b0;
      drive(4'd0, 64'd40, 64'd2);
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      chk("rst_done_valid",    64'(out_valid), 64'd0);
      chk("rst_done_result",   alu_result,     64'd0);
      chk("rst_done_in_ready", 64'(in_ready),  64'd1);
`endif

      drive(4'd0, 64'd1, 64'd1);
      step();
      in_valid = 1'b0;
      chk("post_rst_valid",  64'(out_valid), 64'd1);
      chk("post_rst_result", alu_result,     64'd2);
      chk("post_rst_flags",  64'(alu_flags), 64'b0000);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
